// File: rtl/beta_alu_issue_pkg.sv
// Instruction-format package for the Beta ALU issue stage: field positions,
// opcode encodings, the decoded-instruction struct and decode helpers.
package beta_alu_issue_pkg;

  localparam int DWIDTH  = 32;
  localparam int LIT_W   = 16;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RC_MSB  = 25;
  localparam int RC_LSB  = 21;
  localparam int RA_MSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 11;
  localparam int LIT_MSB = 15;
  localparam int LIT_LSB = 0;

  localparam logic [4:0] REG_ZERO = 5'd31;

  typedef enum logic [5:0] {
    OP_ADD    = 6'h20, OP_SUB    = 6'h21, OP_MUL    = 6'h22, OP_DIV    = 6'h23,
    OP_CMPEQ  = 6'h24, OP_CMPLT  = 6'h25, OP_CMPLE  = 6'h26,
    OP_AND    = 6'h28, OP_OR     = 6'h29, OP_XOR    = 6'h2A, OP_XNOR   = 6'h2B,
    OP_SHL    = 6'h2C, OP_SHR    = 6'h2D, OP_SRA    = 6'h2E,
    OP_ADDC   = 6'h30, OP_SUBC   = 6'h31, OP_MULC   = 6'h32, OP_DIVC   = 6'h33,
    OP_CMPEQC = 6'h34, OP_CMPLTC = 6'h35, OP_CMPLEC = 6'h36,
    OP_ANDC   = 6'h38, OP_ORC    = 6'h39, OP_XORC   = 6'h3A, OP_XNORC  = 6'h3B,
    OP_SHLC   = 6'h3C, OP_SHRC   = 6'h3D, OP_SRAC   = 6'h3E
  } opcode_e;

  typedef struct packed {
    logic [5:0]       opcode;
    logic [4:0]       rc;
    logic [4:0]       ra;
    logic [4:0]       rb;
    logic [LIT_W-1:0] lit;
  } decoded_t;

  // ALU ops occupy 0x20-0x3F, with every xx111 slot left unassigned.
  function automatic logic is_alu_op(input logic [5:0] op);
    return op[5] && (op[2:0] != 3'b111);
  endfunction

  function automatic logic is_lit_form(input logic [5:0] op);
    return op[4];
  endfunction

  function automatic decoded_t decode(input logic [31:0] word);
    decoded_t d;
    d.opcode = word[OP_MSB:OP_LSB];
    d.rc     = word[RC_MSB:RC_LSB];
    d.ra     = word[RA_MSB:RA_LSB];
    d.rb     = word[RB_MSB:RB_LSB];
    d.lit    = word[LIT_MSB:LIT_LSB];
    return d;
  endfunction

endpackage

// File: rtl/beta_alu_issue_operand_sel.sv
// Operand selector: R31 reads as zero, optional writeback bypass
// (BETA_ISSUE_BYPASS_EN), and sign-extended literal for operand B.
module beta_operand_sel
  import beta_alu_issue_pkg::*;
(
  input  logic [4:0]        addr,
  input  logic [DWIDTH-1:0] rf_data,
  input  logic              use_lit,
  input  logic [LIT_W-1:0]  lit,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  output logic [DWIDTH-1:0] operand
);

  logic byp_hit_s;

`ifdef BETA_ISSUE_BYPASS_EN
  assign byp_hit_s = wb_en && (wb_addr == addr) && (wb_addr != REG_ZERO);
`else
  logic unused_wb_s;
  assign unused_wb_s = ^{wb_en, wb_addr, wb_data};
  assign byp_hit_s   = 1'b0;
`endif

  // Operand priority: literal, then hard-wired zero, then bypass, then register file.
  always_comb begin
    operand = rf_data;
    if (use_lit) begin
      operand = {{(DWIDTH-LIT_W){lit[LIT_W-1]}}, lit};
    end else if (addr == REG_ZERO) begin
      operand = {DWIDTH{1'b0}};
`ifdef BETA_ISSUE_BYPASS_EN
    end else if (byp_hit_s) begin
      operand = wb_data;
`endif
    end else begin
      operand = rf_data;
    end
  end

endmodule

// File: rtl/beta_alu_issue.sv
// Beta ALU operand-issue stage: decodes, reads operands, registers them toward
// the ALU and traps on non-ALU opcodes. Optional bypass: BETA_ISSUE_BYPASS_EN.
module beta_alu_issue
  import beta_alu_issue_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       inst,
  output logic [4:0]        ra_addr,
  output logic [4:0]        rb_addr,
  input  logic [DWIDTH-1:0] ra_data,
  input  logic [DWIDTH-1:0] rb_data,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DWIDTH-1:0] wb_data,
  input  logic              flush,
  output logic              alu_valid,
  input  logic              alu_ready,
  output logic [5:0]        alu_opcode,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  output logic [4:0]        alu_rc,
  output logic              trap,
  output logic [5:0]        trap_op,
  input  logic              trap_ack,
  output logic [CNT_W-1:0]  issue_cnt
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_e;

  state_e            state_r, state_nx_s;
  decoded_t          dec_s;
  logic              legal_s, accept_s, handshake_s;
  logic [DWIDTH-1:0] opa_s, opb_s;

  logic              alu_valid_r;
  logic [5:0]        alu_opcode_r, trap_op_r;
  logic [DWIDTH-1:0] alu_a_r, alu_b_r;
  logic [4:0]        alu_rc_r;
  logic [CNT_W-1:0]  issue_cnt_r;

  assign dec_s       = decode(inst);
  assign legal_s     = is_alu_op(dec_s.opcode);
  assign ra_addr     = dec_s.ra;
  assign rb_addr     = dec_s.rb;
  assign inst_ready  = (state_r == ST_RUN) && (!alu_valid_r || alu_ready);
  assign accept_s    = inst_valid && inst_ready;
  assign handshake_s = alu_valid_r && alu_ready;

  beta_operand_sel u_sel_a (
    .addr    (dec_s.ra),
    .rf_data (ra_data),
    .use_lit (1'b0),
    .lit     (dec_s.lit),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .operand (opa_s)
  );

  beta_operand_sel u_sel_b (
    .addr    (dec_s.rb),
    .rf_data (rb_data),
    .use_lit (is_lit_form(dec_s.opcode)),
    .lit     (dec_s.lit),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .operand (opb_s)
  );

  // RUN/TRAP state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state: a surviving illegal accept traps; only trap_ack releases it.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (accept_s && !legal_s && !flush) begin
          state_nx_s = ST_TRAP;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_TRAP: begin
        if (trap_ack) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_TRAP;
        end
      end
      default: state_nx_s = ST_RUN;
    endcase
  end

  // ALU output register; flush wins over a same-cycle load.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_valid_r  <= 1'b0;
      alu_opcode_r <= 6'd0;
      alu_a_r      <= {DWIDTH{1'b0}};
      alu_b_r      <= {DWIDTH{1'b0}};
      alu_rc_r     <= 5'd0;
    end else if (flush) begin
      alu_valid_r  <= 1'b0;
    end else if (accept_s && legal_s) begin
      alu_valid_r  <= 1'b1;
      alu_opcode_r <= dec_s.opcode;
      alu_a_r      <= opa_s;
      alu_b_r      <= opb_s;
      alu_rc_r     <= dec_s.rc;
    end else if (handshake_s) begin
      alu_valid_r  <= 1'b0;
    end else begin
      alu_valid_r  <= alu_valid_r;
    end
  end

  // Trap opcode capture and issued-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_op_r   <= 6'd0;
      issue_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (state_r == ST_RUN && state_nx_s == ST_TRAP) begin
        trap_op_r <= dec_s.opcode;
      end else begin
        trap_op_r <= trap_op_r;
      end
      if (handshake_s && !flush) begin
        issue_cnt_r <= issue_cnt_r + CNT_W'(1);
      end else begin
        issue_cnt_r <= issue_cnt_r;
      end
    end
  end

  assign alu_valid  = alu_valid_r;
  assign alu_opcode = alu_opcode_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_rc     = alu_rc_r;
  assign trap       = (state_r == ST_TRAP);
  assign trap_op    = trap_op_r;
  assign issue_cnt  = issue_cnt_r;

endmodule

// File: tb/tb_beta_alu_issue.sv
// Self-checking bench for beta_alu_issue: behavioural model compared every
// cycle plus directed literal expectations.
module tb_beta_alu_issue;

  logic        clk = 1'b0;
  logic        reset, inst_valid, inst_ready, wb_en, flush;
  logic        alu_valid, alu_ready, trap, trap_ack;
  logic [31:0] inst, ra_data, rb_data, wb_data, alu_a, alu_b;
  logic [4:0]  ra_addr, rb_addr, wb_addr, alu_rc;
  logic [5:0]  alu_opcode, trap_op;
  logic [15:0] issue_cnt;
  logic [31:0] regs [32];

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  beta_alu_issue dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data),
    .rb_data(rb_data), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_rc(alu_rc),
    .trap(trap), .trap_op(trap_op), .trap_ack(trap_ack), .issue_cnt(issue_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {op, rc, ra, rb, 11'd0};
  endfunction

  function automatic logic [31:0] enc_l(input logic [5:0] op, input logic [4:0] rc,
                                        input logic [4:0] ra, input logic [15:0] lit);
    return {op, rc, ra, lit};
  endfunction

  // ---------------- behavioural model ----------------
  logic        m_started = 1'b0;
  logic        m_valid = 1'b0, m_trap = 1'b0;
  logic [5:0]  m_op = 6'd0, m_trap_op = 6'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  logic [4:0]  m_rc = 5'd0;
  logic [15:0] m_cnt = 16'd0;

  function automatic logic legal_op(input logic [5:0] op);
    return (op >= 6'h20 && op <= 6'h26) || (op >= 6'h28 && op <= 6'h2E) ||
           (op >= 6'h30 && op <= 6'h36) || (op >= 6'h38 && op <= 6'h3E);
  endfunction

  function automatic logic [31:0] reg_read(input logic [4:0] r);
    if (r == 5'd31) return 32'd0;
`ifdef BETA_ISSUE_BYPASS_EN
    if (wb_en && wb_addr == r) return wb_data;
`endif
    return regs[r];
  endfunction

  always @(posedge clk) begin : model
    logic       rdy, acc, hs;
    logic [5:0] op;
    op = inst[31:26];
    m_started <= 1'b1;
    if (reset) begin
      m_valid <= 1'b0; m_trap <= 1'b0; m_op <= 6'd0; m_trap_op <= 6'd0;
      m_a <= 32'd0; m_b <= 32'd0; m_rc <= 5'd0; m_cnt <= 16'd0;
    end else begin
      rdy = !m_trap && (!m_valid || alu_ready);
      acc = inst_valid && rdy;
      hs  = m_valid && alu_ready;
      if (hs && !flush) m_cnt <= m_cnt + 16'd1;
      if (flush) m_valid <= 1'b0;
      else if (acc && legal_op(op)) begin
        m_valid <= 1'b1;
        m_op    <= op;
        m_rc    <= inst[25:21];
        m_a     <= reg_read(inst[20:16]);
        m_b     <= op[4] ? {{16{inst[15]}}, inst[15:0]} : reg_read(inst[15:11]);
      end else if (hs) m_valid <= 1'b0;
      if (m_trap && trap_ack) m_trap <= 1'b0;
      else if (acc && !legal_op(op) && !flush) begin
        m_trap    <= 1'b1;
        m_trap_op <= op;
      end
    end
  end

  // Compare process on the falling edge.
  always @(negedge clk) begin
    if (m_started) begin
      check("inst_ready", {31'd0, inst_ready}, {31'd0, !m_trap && (!m_valid || alu_ready)});
      check("ra_addr", {27'd0, ra_addr}, {27'd0, inst[20:16]});
      check("rb_addr", {27'd0, rb_addr}, {27'd0, inst[15:11]});
      check("alu_valid", {31'd0, alu_valid}, {31'd0, m_valid});
      check("trap", {31'd0, trap}, {31'd0, m_trap});
      check("issue_cnt", {16'd0, issue_cnt}, {16'd0, m_cnt});
      if (m_trap) check("trap_op", {26'd0, trap_op}, {26'd0, m_trap_op});
      if (m_valid) begin
        check("alu_opcode", {26'd0, alu_opcode}, {26'd0, m_op});
        check("alu_a", alu_a, m_a);
        check("alu_b", alu_b, m_b);
        check("alu_rc", {27'd0, alu_rc}, {27'd0, m_rc});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, alu_valid}, 32'd0);
    check({tag, "_op"}, {26'd0, alu_opcode}, 32'd0);
    check({tag, "_a"}, alu_a, 32'd0);
    check({tag, "_b"}, alu_b, 32'd0);
    check({tag, "_rc"}, {27'd0, alu_rc}, 32'd0);
    check({tag, "_trap"}, {31'd0, trap}, 32'd0);
    check({tag, "_trap_op"}, {26'd0, trap_op}, 32'd0);
    check({tag, "_cnt"}, {16'd0, issue_cnt}, 32'd0);
    check({tag, "_ready"}, {31'd0, inst_ready}, 32'd1);
  endtask

  logic [31:0] exp_byp;

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    regs[1] = 32'd5; regs[2] = 32'd7; regs[31] = 32'h1234;
    reset = 1'b1; inst_valid = 1'b0; inst = 32'd0; wb_en = 1'b0; wb_addr = 5'd0;
    wb_data = 32'd0; flush = 1'b0; alu_ready = 1'b0; trap_ack = 1'b0;
    step(); step();
    check_all_zero("reset");

    // ADD r3 <- r1, r2
    reset = 1'b0; alu_ready = 1'b1; inst_valid = 1'b1;
    inst = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
    step();
    check("add_valid", {31'd0, alu_valid}, 32'd1);
    check("add_op", {26'd0, alu_opcode}, 32'h20);
    check("add_a", alu_a, 32'd5);
    check("add_b", alu_b, 32'd7);
    check("add_rc", {27'd0, alu_rc}, 32'd3);

    // ADDC r4 <- r31, 0xFFFE
    inst = enc_l(6'h30, 5'd4, 5'd31, 16'hFFFE);
    step();
    check("addc_cnt", {16'd0, issue_cnt}, 32'd1);
    check("addc_a", alu_a, 32'd0);
    check("addc_b", alu_b, 32'hFFFF_FFFE);

    // Stall three cycles with SUB waiting
    alu_ready = 1'b0; inst = enc_r(6'h21, 5'd5, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ready", {31'd0, inst_ready}, 32'd0);
      check("stall_op", {26'd0, alu_opcode}, 32'h30);
      check("stall_b", alu_b, 32'hFFFF_FFFE);
    end

    // Back-to-back issue
    alu_ready = 1'b1;
    step();
    check("b2b_sub_op", {26'd0, alu_opcode}, 32'h21);
    check("b2b_cnt2", {16'd0, issue_cnt}, 32'd2);
    inst = enc_r(6'h29, 5'd6, 5'd1, 5'd2);
    step();
    check("b2b_or_op", {26'd0, alu_opcode}, 32'h29);
    inst = enc_l(6'h35, 5'd6, 5'd2, 16'd5);
    step();
    check("b2b_cmpltc_a", alu_a, 32'd7);
    check("b2b_cmpltc_b", alu_b, 32'd5);
    check("b2b_cnt4", {16'd0, issue_cnt}, 32'd4);
    inst_valid = 1'b0;
    step();
    check("drain_cnt", {16'd0, issue_cnt}, 32'd5);

    // Illegal opcode LD traps
    inst_valid = 1'b1; inst = enc_r(6'h18, 5'd1, 5'd2, 5'd3);
    step();
    check("ld_trap", {31'd0, trap}, 32'd1);
    check("ld_trap_op", {26'd0, trap_op}, 32'h18);
    check("ld_no_valid", {31'd0, alu_valid}, 32'd0);
    check("ld_ready", {31'd0, inst_ready}, 32'd0);
    inst = enc_r(6'h20, 5'd3, 5'd1, 5'd2);
    step();
    check("trap_held", {31'd0, trap}, 32'd1);
    trap_ack = 1'b1;
    step();
    check("trap_cleared", {31'd0, trap}, 32'd0);
    check("trap_ack_no_issue", {31'd0, alu_valid}, 32'd0);
    trap_ack = 1'b0;
    step();
    check("post_trap_issue", {31'd0, alu_valid}, 32'd1);

    // Flush while stalled, then flush against a same-cycle accept
    inst_valid = 1'b0; alu_ready = 1'b0;
    step();
    flush = 1'b1;
    step();
    check("flush_valid", {31'd0, alu_valid}, 32'd0);
    check("flush_cnt", {16'd0, issue_cnt}, 32'd5);
    alu_ready = 1'b1; inst_valid = 1'b1;
    step();
    check("flush_accept_valid", {31'd0, alu_valid}, 32'd0);
    flush = 1'b0;

    // Reset in the middle of a stall
    alu_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    reset = 1'b0; inst_valid = 1'b0;
    step();

    // Writeback bypass
`ifdef BETA_ISSUE_BYPASS_EN
    exp_byp = 32'hAA;
`else
    exp_byp = 32'd0;
`endif
    regs[1] = 32'd0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hAA;
    alu_ready = 1'b1; inst_valid = 1'b1; inst = enc_r(6'h20, 5'd7, 5'd1, 5'd2);
    step();
    check("byp_a", alu_a, exp_byp);
    inst = enc_r(6'h20, 5'd8, 5'd2, 5'd1);
    step();
    check("byp_b", alu_b, exp_byp);
    inst = enc_l(6'h30, 5'd9, 5'd2, 16'h0800);
    step();
    check("byp_lit_b", alu_b, 32'h800);
    inst_valid = 1'b0; wb_en = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/beta_alu_issue.md
Name: beta_alu_issue

Overview:
- Operand-issue stage that feeds the ALU.
- Accepts a 32-bit Beta instruction word on a valid/ready handshake and decodes the opcode, Rc, Ra, Rb and literal fields.
- Reads the register file, selects Rb or the sign-extended literal, and registers opcode/operands/destination toward the ALU on a second valid/ready handshake.
- Non-ALU or undefined opcodes halt issue and raise a trap until acknowledged.

Parameters:
- DWIDTH, 32, datapath width; taken from InstructionStruct, not overridden locally.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- inst_valid  in  1  instruction word present
- inst_ready  out  1  stage can accept instruction
- inst  in  32  instruction: opcode[31:26], rc[25:21], ra[20:16], rb[15:11], lit[15:0]
- ra_addr  out  5  register-file read address A (combinational = inst[20:16])
- rb_addr  out  5  register-file read address B (combinational = inst[15:11])
- ra_data  in  DWIDTH  register-file read data A (same-cycle)
- rb_data  in  DWIDTH  register-file read data B (same-cycle)
- wb_en  in  1  writeback write enable this cycle
- wb_addr  in  5  writeback destination
- wb_data  in  DWIDTH  writeback value
- flush  in  1  discard held instruction
- alu_valid  out  1  issued operation valid
- alu_ready  in  1  ALU side accepts
- alu_opcode  out  6  opcode to ALU
- alu_a  out  DWIDTH  operand A
- alu_b  out  DWIDTH  operand B (register or literal)
- alu_rc  out  5  destination register
- trap  out  1  illegal opcode held
- trap_op  out  6  offending opcode
- trap_ack  in  1  clears trap
- issue_cnt  out  CNT_W  count of ALU handshakes completed

Behaviour:
- Reset values:
  - All outputs 0; state RUN.
  - inst_ready is combinational (see below), so it reads 1 while reset is high.
- Legal opcodes:
  - Register form: 0x20–0x26, 0x28–0x2E.
  - Literal form: 0x30–0x36, 0x38–0x3E.
  - All others are illegal.
- Operand A = ra_data, except:
  - ra==31 gives 0.
- Operand B:
  - Literal form (opcode[4]=1): lit sign-extended to DWIDTH.
  - Register form: rb_data, except rb==31 gives 0.
- Handshakes and timing:
  - inst_ready = (state==RUN) && (!alu_valid || alu_ready).
  - Instruction accepted when inst_valid && inst_ready.
  - A legal accepted instruction loads the output register next edge; latency 1 cycle.
  - alu_* fields are stable while alu_valid && !alu_ready.
  - alu_valid clears after handshake unless a new instruction is loaded in the same cycle, giving full throughput.
- State machine RUN/TRAP:
  - RUN: an accepted illegal opcode does not load the output register. Next state TRAP; trap=1 and trap_op latched.
  - TRAP: inst_ready=0. A pending alu_valid still drains normally.
  - trap_ack in TRAP returns to RUN next edge with trap=0. trap_ack in RUN is ignored.
- flush:
  - Clears alu_valid next edge; issue_cnt is unchanged for the flushed entry.
  - An instruction accepted the same cycle is discarded.
  - Does not affect TRAP state.
  - flush has priority over a load.
- issue_cnt:
  - Increments on alu_valid && alu_ready && !flush.
  - Wraps from all-ones to 0.
- reset mid-operation: held instruction dropped, trap cleared, counter zeroed.

Optional Feature:
- Macro: BETA_ISSUE_BYPASS_EN.
- Defined: wb_data substitutes for a register read if wb_en && wb_addr==that read address && wb_addr!=31. The check applies independently to A and B; B applies in register form only.
- Undefined: wb_* ports remain but are ignored, and the register file's read-during-write behaviour applies.

Decomposition:
- Add to InstructionStruct:
  - Field-position constants.
  - Opcode enums (reuse existing ADD…CMPLEC).
  - A typedef'd packed struct for the decoded instruction.
  - An is_alu_op function.
- One natural sub-module: beta_operand_sel (R31 zeroing, bypass mux, literal sign-extension), instantiated twice or parameterised for A/B.

Test Plan:
- ADD r3←r1,r2 with ra_data=5, rb_data=7, alu_ready=1 -> next cycle alu_valid=1, opcode 0x20, a=5, b=7, rc=3; issue_cnt=1 after handshake.
- ADDC lit=0xFFFE -> alu_b=0xFFFFFFFE. Ra=31 with ra_data=0x1234 -> alu_a=0.
- alu_ready=0 for 3 cycles with inst_valid held -> inst_ready=0 and alu_* stable. Then back-to-back instructions at alu_ready=1 -> one issue per cycle.
- Opcode 0x18 (LD) -> trap=1, trap_op=0x18, inst_ready=0, no alu_valid. trap_ack -> RUN next cycle and the following ADD issues.
- flush while alu_valid=1, alu_ready=0 -> alu_valid=0 next cycle, issue_cnt unchanged. Reset asserted mid-stall -> all outputs 0.
- With BETA_ISSUE_BYPASS_EN: wb_en=1, wb_addr=1, wb_data=0xAA, instruction reading r1 with ra_data=0 -> alu_a=0xAA. Same stimulus without the macro -> alu_a=0.
